mcycle_unit: RTL and testbench

//  Iterative multi-cycle multiply/divide unit in the Execute stage, beside the ALU.

---
 rtl/mcycle_pkg.sv | 36 +++
 rtl/mcycle_div_step.sv | 28 ++
 rtl/mcycle_unit.sv | 184 ++++++++++++++++++
 tb/tb_mcycle_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings and op-field bit positions
//   - FSM state type
//   - wide abs/negate helpers; callers zero-extend to MCYCLE_MAX_W and
//     truncate the result back, which keeps two's-complement semantics
//     for any operand up to MCYCLE_MAX_W bits (products up to 2*64 bits).
package mcycle_pkg;

    localparam int unsigned MCYCLE_MAX_W = 128;

    localparam logic [1:0] MCYCLE_MUL_U = 2'b00;
    localparam logic [1:0] MCYCLE_MUL_S = 2'b01;
    localparam logic [1:0] MCYCLE_DIV_U = 2'b10;
    localparam logic [1:0] MCYCLE_DIV_S = 2'b11;

    // Bit 0 of the op selects signed operation, bit 1 selects divide.
    localparam int unsigned MCYCLE_OP_SIGNED = 0;
    localparam int unsigned MCYCLE_OP_DIV    = 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    function automatic logic [MCYCLE_MAX_W-1:0] mcycle_negate(input logic [MCYCLE_MAX_W-1:0] x);
        return -x;
    endfunction

    // Magnitude of x when neg is the sign flag; also restores a sign later.
    function automatic logic [MCYCLE_MAX_W-1:0] mcycle_abs(input logic [MCYCLE_MAX_W-1:0] x,
                                                           input logic                    neg);
        return neg ? mcycle_negate(x) : x;
    endfunction

endpackage

// File: rtl/mcycle_div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem          partial remainder before the step
//   dividend_bit next dividend bit shifted into the remainder
//   divisor      divisor magnitude
//   rem_next     partial remainder after the step
//   q_bit        quotient bit produced by the step
module mcycle_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    assign partial = {rem, dividend_bit};
    assign diff    = partial - {1'b0, divisor};

    // No borrow out of the trial subtraction means the divisor fits.
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multi-cycle multiply/divide unit (Execute stage).
// Build option: define MCYCLE_DIV_EN to include the divider datapath;
// without it, divide ops complete in one edge with zero results.
// Ports:
//   CLK, Reset         clock (rising edge), async active-low reset
//   Start              request, sampled only in IDLE
//   MCycleOp           00 mul_u, 01 mul_s, 10 div_u, 11 div_s
//   Operand1/Operand2  multiplicand/dividend, multiplier/divisor
//   Result1/Result2    low product/quotient, high product/remainder
//   Busy               combinational stall request
//   Done               one-cycle completion pulse
// WIDTH must be a power of two no larger than 64.
module mcycle_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);
    import mcycle_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_iter;
    logic [CW-1:0]    count;
    logic             neg_res;
    logic [WIDTH-1:0] opnd_q;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_next;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_acc;
    logic [AW-1:0]    prod;
    logic [WIDTH-1:0] res1;
    logic [WIDTH-1:0] res2;
`ifdef MCYCLE_DIV_EN
    logic             is_div;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;
    logic [AW-1:0]    div_acc;
`endif

    // Operand magnitudes; only signed ops take the absolute value.
    assign a_abs = WIDTH'(mcycle_abs(MCYCLE_MAX_W'(Operand1), MCycleOp[MCYCLE_OP_SIGNED] & Operand1[WIDTH-1]));
    assign b_abs = WIDTH'(mcycle_abs(MCYCLE_MAX_W'(Operand2), MCycleOp[MCYCLE_OP_SIGNED] & Operand2[WIDTH-1]));

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, accept/last-iteration strobes and the stall request
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        Busy       = 1'b0;
        case (state)
            IDLE: begin
                Busy = Start;
                if (Start) begin
                    accept = 1'b1;
`ifdef MCYCLE_DIV_EN
                    state_next = COMPUTE;
`else
                    state_next = MCycleOp[MCYCLE_OP_DIV] ? DONE : COMPUTE;
`endif
                end
            end
            COMPUTE: begin
                Busy = 1'b1;
                if (count == '0) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Done = (state == DONE);

    // Shift-add step: acc = {high partial product, remaining multiplier bits}
    assign mul_sum = (WIDTH+1)'(acc[AW-1:WIDTH]) + (WIDTH+1)'(acc[0] ? opnd_q : '0);
    assign mul_acc = {mul_sum, acc[WIDTH-1:1]};

`ifdef MCYCLE_DIV_EN
    // Restoring step: acc = {partial remainder, dividend bits / quotient bits}
    mcycle_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem          (acc[AW-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (opnd_q),
        .rem_next     (div_rem),
        .q_bit        (div_q)
    );
    assign div_acc  = {div_rem, acc[WIDTH-2:0], div_q};
    assign acc_next = is_div ? div_acc : mul_acc;
`else
    assign acc_next = mul_acc;
`endif

    // Sign correction applied to the value produced by the final iteration
    assign prod = AW'(mcycle_abs(MCYCLE_MAX_W'(acc_next), neg_res));

`ifdef MCYCLE_DIV_EN
    // Divide by zero: the remainder path already yields the raw dividend.
    assign res1 = !is_div  ? prod[WIDTH-1:0] :
                  div_zero ? '1 :
                  WIDTH'(mcycle_abs(MCYCLE_MAX_W'(acc_next[WIDTH-1:0]), neg_res));
    assign res2 = !is_div  ? prod[AW-1:WIDTH] :
                  WIDTH'(mcycle_abs(MCYCLE_MAX_W'(acc_next[AW-1:WIDTH]), neg_rem));
`else
    assign res1 = prod[WIDTH-1:0];
    assign res2 = prod[AW-1:WIDTH];
`endif

    // Operand capture, iteration and result registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            count   <= '0;
            neg_res <= 1'b0;
            opnd_q  <= '0;
            acc     <= '0;
            Result1 <= '0;
            Result2 <= '0;
`ifdef MCYCLE_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else if (accept) begin
            count   <= CW'(WIDTH - 1);
            neg_res <= MCycleOp[MCYCLE_OP_SIGNED] & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
`ifdef MCYCLE_DIV_EN
            is_div   <= MCycleOp[MCYCLE_OP_DIV];
            neg_rem  <= MCycleOp[MCYCLE_OP_SIGNED] & Operand1[WIDTH-1];
            div_zero <= (Operand2 == '0);
            opnd_q   <= MCycleOp[MCYCLE_OP_DIV] ? b_abs : a_abs;
            acc      <= {WIDTH'(0), MCycleOp[MCYCLE_OP_DIV] ? a_abs : b_abs};
`else
            opnd_q <= a_abs;
            acc    <= {WIDTH'(0), b_abs};
            // Divide ops finish on this edge with zero results.
            if (MCycleOp[MCYCLE_OP_DIV]) begin
                Result1 <= '0;
                Result2 <= '0;
            end
`endif
        end else if (state == COMPUTE) begin
            acc   <= acc_next;
            count <= count - CW'(1);
            if (last_iter) begin
                Result1 <= res1;
                Result2 <= res2;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: a timestamp-based reference model
// predicts Busy/Done/Result1/Result2 every cycle; directed vectors pin the
// arithmetic and latency, then randomized ops exercise the rest.
`timescale 1ns/1ps
module tb_mcycle_unit;

    localparam int unsigned W = 32;
`ifdef MCYCLE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         CLK      = 1'b0;
    logic         Reset    = 1'b1;
    logic         Start    = 1'b0;
    logic [1:0]   MCycleOp = 2'b00;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         Done;

    int checks   = 0;
    int failures = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {Result2, Result1} from plain integer arithmetic.
    function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa;
        int     sb;
        longint la;
        longint lb;
        logic [63:0] p;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        case (op)
            2'b00: p = {32'h0, a} * {32'h0, b};
            2'b01: p = 64'(la * lb);
            2'b10: begin
                if (!DIV_EN)     p = '0;
                else if (b == 0) p = {a, 32'hFFFF_FFFF};
                else             p = {a % b, a / b};
            end
            default: begin
                if (!DIV_EN)     p = '0;
                else if (b == 0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else             p = {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
        return p;
    endfunction

    // Edges from acceptance until the Done cycle begins.
    function automatic int op_lat(input logic [1:0] op);
        return (op[1] && !DIV_EN) ? 0 : int'(W);
    endfunction

    // Reference model: m_edge counts edges since reset; an accepted op
    // is in flight until edge m_done_at, after which Done is visible.
    logic        m_active  = 1'b0;
    int          m_edge    = 0;
    int          m_done_at = 0;
    logic [63:0] m_pend    = '0;
    logic [63:0] m_exp     = '0;

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            m_active <= 1'b0;
            m_exp    <= '0;
            m_edge   <= 0;
        end else begin
            m_edge <= m_edge + 1;
            if ((!m_active || m_edge > m_done_at) && Start) begin
                m_active  <= 1'b1;
                m_done_at <= m_edge + 1 + op_lat(MCycleOp);
                m_pend    <= calc(MCycleOp, Operand1, Operand2);
                if (op_lat(MCycleOp) == 0) m_exp <= calc(MCycleOp, Operand1, Operand2);
            end else if (m_active && m_edge + 1 == m_done_at) begin
                m_exp <= m_pend;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("done", 64'(Done), 64'(m_active && m_edge == m_done_at));
        chk("busy", 64'(Busy), 64'((m_active && m_edge < m_done_at) ||
                                   ((!m_active || m_edge > m_done_at) && Start)));
        chk("result1", 64'(Result1), 64'(m_exp[31:0]));
        chk("result2", 64'(Result2), 64'(m_exp[63:32]));
    end

    // Issue one op from IDLE; returns edges from acceptance to Done (-1 on timeout).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_start, output int lat);
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        @(posedge CLK); #1;
        if (!hold_start) Start = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = 2'($urandom_range(0, 3));
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) begin
                @(posedge CLK); #1;
            end
            if (Done) begin
                lat = i;
                break;
            end
        end
        Start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] r1, input logic [31:0] r2);
        int lat;
        run_op(op, a, b, 1'b0, lat);
        chk({name, "_lat"}, 64'(lat), 64'(op_lat(op)));
        chk({name, "_r1"}, 64'(Result1), 64'(r1));
        chk({name, "_r2"}, 64'(Result2), 64'(r2));
    endtask

    initial begin
        int lat;
        int dn;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        #1 Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_r1", 64'(Result1), 64'h0);
        chk("reset_r2", 64'(Result2), 64'h0);
        chk("reset_busy", 64'(Busy), 64'h0);
        chk("reset_done", 64'(Done), 64'h0);
        Reset = 1'b1;

        // Pin the model against hand-computed values.
        chk("model_mulu", calc(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_muls", calc(2'b01, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
`ifdef MCYCLE_DIV_EN
        chk("model_divs", calc(2'b11, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_div0", calc(2'b10, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);
        chk("model_ovf", calc(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
`else
        chk("model_divoff", calc(2'b10, 32'd100, 32'd0), 64'h0);
`endif

        directed("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        directed("muls_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
`ifdef MCYCLE_DIV_EN
        directed("divs_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        directed("divu_zero", 2'b10, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100);
        directed("divs_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
`else
        directed("divu_off", 2'b10, 32'd100, 32'd3, 32'h0, 32'h0);
`endif
        directed("muls_pos", 2'b01, 32'd6, 32'd7, 32'd42, 32'h0);

        // Abort a multiply with reset partway through COMPUTE.
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'h1234_5678; Operand2 = 32'h9ABC_DEF0;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (10) @(posedge CLK);
        #1 Reset = 1'b0;
        #1;
        chk("abort_r1", 64'(Result1), 64'h0);
        chk("abort_r2", 64'(Result2), 64'h0);
        chk("abort_busy", 64'(Busy), 64'h0);
        chk("abort_done", 64'(Done), 64'h0);
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (Done) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'h0);

        // Start held high through COMPUTE must not restart the op.
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b1, lat);
        chk("hold_lat", 64'(lat), 64'd32);
        chk("hold_r1", 64'(Result1), 64'hFFFF_FFEB);
        chk("hold_r2", 64'(Result2), 64'hFFFF_FFFF);

        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            run_op(op, a, b, 1'($urandom_range(0, 1)), lat);
            chk("rand_lat", 64'(lat), 64'(op_lat(op)));
            chk("rand_res", {Result2, Result1}, calc(op, a, b));
        end

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
